// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle datapath arithmetic units (divider, multiplier).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

   // Default datapath width; only 32 is exercised.
   localparam int DATA_WIDTH = 32;

   // Edges from the start-sampling edge to the edge that raises done.
   localparam int DIV_LATENCY = 34;

   // Divider sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      ITER = 2'd2,
      FIX  = 2'd3
   } div_state_t;

endpackage : mips_pkg

// File: rtl/div_unit_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
// Latency: n/a (wiring only).
// Backpressure: none; the master must watch busy/done and holds off start while busy.
interface div_unit_if #(
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
);

   logic                  start;
   logic [DATA_WIDTH-1:0] dividend;
   logic [DATA_WIDTH-1:0] divisor;
   logic                  busy;
   logic                  done;
   logic                  div_zero;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (
      output start, dividend, divisor,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, div_zero, hi, lo
   );

endinterface : div_unit_if

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift the next quotient bit into the remainder, trial-subtract.
// Latency: combinational.
// Backpressure: n/a.
module div_step #(
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] rem_i,
   input  logic [DATA_WIDTH-1:0] q_i,
   input  logic [DATA_WIDTH:0]   dvs_mag_i,
   output logic [DATA_WIDTH-1:0] rem_o,
   output logic [DATA_WIDTH-1:0] q_o
);
   import mips_pkg::*;

   logic [DATA_WIDTH:0] rem_sh;
   logic [DATA_WIDTH:0] diff;

   // The remainder is always below |divisor| <= 2^31, so its top bit is zero and the
   // 33-bit shifted value equals the 32-bit {rem[30:0], q[31]}; 33 bits keeps the
   // compare against a 2^31 divisor exact.
   always_comb begin
      rem_sh = {rem_i, q_i[DATA_WIDTH-1]};
      diff   = rem_sh - dvs_mag_i;
      if (rem_sh >= dvs_mag_i) begin
         rem_o = diff[DATA_WIDTH-1:0];
         q_o   = {q_i[DATA_WIDTH-2:0], 1'b1};
      end else begin
         rem_o = rem_sh[DATA_WIDTH-1:0];
         q_o   = {q_i[DATA_WIDTH-2:0], 1'b0};
      end
   end

   // Top bits are provably zero after a successful step; kept only for the compare.
   logic unused_top_bits;
   assign unused_top_bits = rem_sh[DATA_WIDTH] ^ diff[DATA_WIDTH];

endmodule : div_step

// File: rtl/div_unit.sv
// Iterative signed divider, MIPS div semantics: LO = quotient (toward zero), HI = remainder (sign of dividend).
// Latency: done rises DIV_LATENCY edges after the start edge; divide-by-zero answers on the next edge.
// Backpressure: start is ignored while busy; results hold in hi/lo until the next completed divide.
module div_unit #(
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
   input  logic       clk,
   input  logic       reset,
   div_unit_if.slave  bus
);
   import mips_pkg::*;

   localparam int CW = $clog2(DATA_WIDTH);

   div_state_t            state_q, state_d;
   logic [DATA_WIDTH:0]   dvd_mag_q, dvd_mag_d;
   logic [DATA_WIDTH:0]   dvs_mag_q, dvs_mag_d;
   logic                  neg_dvd_q, neg_dvd_d;
   logic                  neg_dvs_q, neg_dvs_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] hi_q, hi_d;
   logic [DATA_WIDTH-1:0] lo_q, lo_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  div_zero_q, div_zero_d;

   logic [DATA_WIDTH-1:0] step_rem;
   logic [DATA_WIDTH-1:0] step_quo;
   logic                  accept;
   logic                  zero_req;

   // Sign-extend to one extra bit before negating so |-2^31| is representable.
   function automatic logic [DATA_WIDTH:0] mag_ext(input logic [DATA_WIDTH-1:0] x);
      logic [DATA_WIDTH:0] ext;
      ext = {x[DATA_WIDTH-1], x};
      return x[DATA_WIDTH-1] ? -ext : ext;
   endfunction

   assign zero_req = (state_q == IDLE) && bus.start && (bus.divisor == '0);
   assign accept   = (state_q == IDLE) && bus.start && (bus.divisor != '0);

   div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem_i     (rem_q),
      .q_i       (quo_q),
      .dvs_mag_i (dvs_mag_q),
      .rem_o     (step_rem),
      .q_o       (step_quo)
   );

   // State and datapath registers; reset aborts any divide in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         dvd_mag_q  <= '0;
         dvs_mag_q  <= '0;
         neg_dvd_q  <= 1'b0;
         neg_dvs_q  <= 1'b0;
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dvd_mag_q  <= dvd_mag_d;
         dvs_mag_q  <= dvs_mag_d;
         neg_dvd_q  <= neg_dvd_d;
         neg_dvs_q  <= neg_dvs_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   // Sequencer: a zero divisor never leaves IDLE, otherwise PREP -> 32 x ITER -> FIX.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = PREP;
         PREP:    state_d = ITER;
         ITER:    if (cnt_q == '0) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs; hi/lo only move in FIX.
   always_comb begin
      dvd_mag_d  = dvd_mag_q;
      dvs_mag_d  = dvs_mag_q;
      neg_dvd_d  = neg_dvd_q;
      neg_dvs_d  = neg_dvs_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (zero_req) begin
               done_d     = 1'b1;
               div_zero_d = 1'b1;
            end else if (accept) begin
               dvd_mag_d = mag_ext(bus.dividend);
               dvs_mag_d = mag_ext(bus.divisor);
               neg_dvd_d = bus.dividend[DATA_WIDTH-1];
               neg_dvs_d = bus.divisor[DATA_WIDTH-1];
               busy_d    = 1'b1;
            end
         end
         PREP: begin
            rem_d = '0;
            quo_d = dvd_mag_q[DATA_WIDTH-1:0];
            cnt_d = CW'(DATA_WIDTH - 1);
         end
         ITER: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
         end
         FIX: begin
            lo_d   = (neg_dvd_q ^ neg_dvs_q) ? -quo_q : quo_q;
            hi_d   = neg_dvd_q ? -rem_q : rem_q;
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   // |dividend| never exceeds 2^31, so its extension bit carries no information here.
   logic unused_dvd_msb;
   assign unused_dvd_msb = dvd_mag_q[DATA_WIDTH];

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: signed cases, latency, divide-by-zero, overflow wrap, ignored start, reset abort.
// Latency: checks done at DIV_LATENCY edges after start.
// Backpressure: exercises start-while-busy and start in the done cycle.
module tb_div_unit;
   import mips_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   div_unit_if #(.DATA_WIDTH(32)) bus ();

   div_unit #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Issue one divide; returns edges to done (0 for div-by-zero, -1 on timeout),
   // busy-high cycles and div_zero at done. Ends #1 after the done edge.
   task automatic run_div(input logic [31:0] dvd, input logic [31:0] dvs,
                          output int edges, output int busy_cnt, output logic dz);
      edges    = -1;
      busy_cnt = 0;
      dz       = 1'b0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = 32'hDEAD_BEEF;
      bus.divisor  = 32'h0000_0000;
      if (bus.done) begin
         edges = 0;
         dz    = bus.div_zero;
      end else begin
         busy_cnt = int'(bus.busy);
         for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
               edges = i;
               dz    = bus.div_zero;
               break;
            end
            busy_cnt += int'(bus.busy);
         end
      end
   endtask

   initial begin
      int   edges;
      int   busy_cnt;
      int   cnt;
      logic dz;

      n_checks     = 0;
      n_pass       = 0;
      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      #2;
      chk("rst_hi", bus.hi, 32'h0);
      chk("rst_lo", bus.lo, 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_divzero", 32'(bus.div_zero), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // 7 / 2
      run_div(32'd7, 32'd2, edges, busy_cnt, dz);
      chk("t1_latency", 32'(edges), 32'(DIV_LATENCY));
      chk("t1_busy_cycles", 32'(busy_cnt), 32'd34);
      chk("t1_lo", bus.lo, 32'd3);
      chk("t1_hi", bus.hi, 32'd1);
      chk("t1_divzero", 32'(dz), 32'h0);
      @(posedge clk);
      #1;
      chk("t1_done_pulse", 32'(bus.done), 32'h0);

      // signed combinations; each start lands in the previous done cycle
      run_div(-32'sd7, 32'd2, edges, busy_cnt, dz);
      chk("t2_lo", bus.lo, 32'hFFFF_FFFD);
      chk("t2_hi", bus.hi, 32'hFFFF_FFFF);
      run_div(32'd7, -32'sd2, edges, busy_cnt, dz);
      chk("t3_latency", 32'(edges), 32'd34);
      chk("t3_lo", bus.lo, 32'hFFFF_FFFD);
      chk("t3_hi", bus.hi, 32'd1);
      run_div(-32'sd7, -32'sd2, edges, busy_cnt, dz);
      chk("t4_lo", bus.lo, 32'd3);
      chk("t4_hi", bus.hi, 32'hFFFF_FFFF);

      // preload hi=0x1234, lo=0x5678, then divide by zero
      run_div(32'h5678_1234, 32'h0001_0000, edges, busy_cnt, dz);
      chk("pre_lo", bus.lo, 32'h5678);
      chk("pre_hi", bus.hi, 32'h1234);
      run_div(32'd100, 32'd0, edges, busy_cnt, dz);
      chk("dz_latency", 32'(edges), 32'd0);
      chk("dz_flag", 32'(dz), 32'h1);
      chk("dz_busy", 32'(busy_cnt), 32'h0);
      chk("dz_lo", bus.lo, 32'h5678);
      chk("dz_hi", bus.hi, 32'h1234);
      @(posedge clk);
      #1;
      chk("dz_done_pulse", 32'(bus.done), 32'h0);
      chk("dz_flag_pulse", 32'(bus.div_zero), 32'h0);

      // most negative / -1 wraps without exception
      run_div(32'h8000_0000, 32'hFFFF_FFFF, edges, busy_cnt, dz);
      chk("ovf_lo", bus.lo, 32'h8000_0000);
      chk("ovf_hi", bus.hi, 32'h0);
      chk("ovf_divzero", 32'(dz), 32'h0);

      // 100 / 7 with an ignored 9 / 3 start at cycle 10
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd100;
      bus.divisor  = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      edges = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (i == 10) bus.start = 1'b0;
         if (bus.done) begin
            edges = i;
            break;
         end
         if (i == 9) begin
            bus.start    = 1'b1;
            bus.dividend = 32'd9;
            bus.divisor  = 32'd3;
         end
      end
      chk("ign_latency", 32'(edges), 32'd34);
      chk("ign_lo", bus.lo, 32'd14);
      chk("ign_hi", bus.hi, 32'd2);
      @(posedge clk);
      #1;
      chk("ign_no_restart", 32'(bus.busy), 32'h0);

      // reset at cycle 12 of a divide
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor  = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (12) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("abort_hi", bus.hi, 32'h0);
      chk("abort_lo", bus.lo, 32'h0);
      chk("abort_busy", 32'(bus.busy), 32'h0);
      chk("abort_done", 32'(bus.done), 32'h0);
      chk("abort_divzero", 32'(bus.div_zero), 32'h0);
      chk("abort_state", 32'(dut.state_q), 32'(IDLE));
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         cnt += int'(bus.done) + int'(bus.busy);
      end
      chk("abort_quiet", 32'(cnt), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_div_unit
